id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 29 ++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared decode control bundle for the ID/EX stage
// Purpose : single definition of the decoder control bundle carried from ID
//           into EX, plus the helper telling whether an instruction reads rt.
// Contents: ctrl_t     - packed control bits, MSB first
//           CTRL_W     - width of the control bundle
//           reads_rt() - 1 when the instruction consumes the rt register value
package id_ex_stage_pkg;

   typedef struct packed {
      logic reg_dst;
      logic reg_write;
      logic ext_op;
      logic alu_src;
      logic mem_write;
      logic mem_to_reg;
      logic beq;
      logic bne;
      logic j;
   } ctrl_t;

   localparam int CTRL_W = $bits(ctrl_t);

   // R-type ops, stores and branches read rt; immediate ALU ops and loads
   // only use rt as a destination, so they cannot create an rt hazard.
   function automatic logic reads_rt(input ctrl_t c);
      return c.reg_dst | c.mem_write | c.beq | c.bne;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard compare between EX and ID slots
// Purpose : raises hazard when the load in EX writes a register the decode
//           slot needs next cycle. Purely combinational.
// Ports   : ex_valid, ex_mem_to_reg, ex_wreg - load currently in EX
//           id_valid, id_rs, id_rt, id_ctrl   - instruction in decode
//           hazard                            - load-use hazard detected
module load_use_detect
   import id_ex_stage_pkg::*;
(
   input  logic       ex_valid,
   input  logic       ex_mem_to_reg,
   input  logic [4:0] ex_wreg,
   input  logic       id_valid,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  ctrl_t      id_ctrl,
   output logic       hazard
);

   logic rs_match;
   logic rt_match;

   // $0 is hard-wired, so a load targeting it never produces a real value.
   assign rs_match = (ex_wreg == id_rs);
   assign rt_match = (ex_wreg == id_rt) & reads_rt(id_ctrl);
   assign hazard   = ex_valid & ex_mem_to_reg & id_valid & (ex_wreg != 5'd0)
                   & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush
// Purpose : captures decoded controls and operands into EX, inserts a bubble
//           on flush or load-use hazard, counts stall and flush cycles.
// Ports   : clk, rst_n                 - clock, async active-low reset
//           id_*                       - decode slot controls and operands
//           flush                      - taken branch/jump kills decode slot
//           ex_*                       - registered EX copies (ex_imm extended)
//           stall                      - hold PC and IF/ID this cycle
//           stall_cnt, flush_cnt       - saturating event counters
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic              id_reg_dst,
   input  logic              id_reg_write,
   input  logic              id_ext_op,
   input  logic              id_alu_src,
   input  logic              id_mem_write,
   input  logic              id_mem_to_reg,
   input  logic              id_beq,
   input  logic              id_bne,
   input  logic              id_j,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm16,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic [4:0]        id_rd,
   input  logic [5:0]        id_funct,
   input  logic              flush,
   output logic              ex_valid,
   output logic              ex_reg_dst,
   output logic              ex_reg_write,
   output logic              ex_ext_op,
   output logic              ex_alu_src,
   output logic              ex_mem_write,
   output logic              ex_mem_to_reg,
   output logic              ex_beq,
   output logic              ex_bne,
   output logic              ex_j,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [4:0]        ex_rs,
   output logic [4:0]        ex_rt,
   output logic [4:0]        ex_wreg,
   output logic [5:0]        ex_funct,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   ctrl_t             id_ctrl;
   ctrl_t             ex_ctrl;
   logic              hazard;
   logic              bubble;
   logic [DATA_W-1:0] imm_ext;

   assign id_ctrl = '{reg_dst: id_reg_dst, reg_write: id_reg_write,
                      ext_op: id_ext_op, alu_src: id_alu_src,
                      mem_write: id_mem_write, mem_to_reg: id_mem_to_reg,
                      beq: id_beq, bne: id_bne, j: id_j};

   load_use_detect u_load_use_detect (
      .ex_valid      (ex_valid),
      .ex_mem_to_reg (ex_ctrl.mem_to_reg),
      .ex_wreg       (ex_wreg),
      .id_valid      (id_valid),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_ctrl       (id_ctrl),
      .hazard        (hazard)
   );

   // A flush already discards the decode slot, so holding it would be pointless.
   assign stall  = hazard & ~flush;
   assign bubble = flush | stall;

   assign imm_ext = {{(DATA_W-16){id_imm16[15] & id_ext_op}}, id_imm16};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= '0;
         ex_pc4     <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_wreg    <= '0;
         ex_funct   <= '0;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         if (bubble) begin
            // Datapath fields are left holding; only valid/controls matter.
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
         end else begin
            ex_valid   <= id_valid;
            ex_ctrl    <= id_valid ? id_ctrl : ctrl_t'('0);
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= imm_ext;
            ex_rs      <= id_rs;
            ex_rt      <= id_rt;
            ex_wreg    <= id_reg_dst ? id_rd : id_rt;
            ex_funct   <= id_funct;
         end
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

   assign ex_reg_dst    = ex_ctrl.reg_dst;
   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_ext_op     = ex_ctrl.ext_op;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_beq        = ex_ctrl.beq;
   assign ex_bne        = ex_ctrl.bne;
   assign ex_j          = ex_ctrl.j;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - scoreboard bench for id_ex_stage
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int CW = 4;

   // control vector order: reg_dst,reg_write,ext_op,alu_src,mem_write,mem_to_reg,beq,bne,j
   localparam logic [8:0] C_LW  = 9'h0E8;
   localparam logic [8:0] C_ADD = 9'h180;
   localparam logic [8:0] C_ADDI_S = 9'h0E0;
   localparam logic [8:0] C_ADDI_Z = 9'h0A0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          id_valid, id_reg_dst, id_reg_write, id_ext_op, id_alu_src;
   logic          id_mem_write, id_mem_to_reg, id_beq, id_bne, id_j, flush;
   logic [DW-1:0] id_pc4, id_rs_data, id_rt_data;
   logic [15:0]   id_imm16;
   logic [4:0]    id_rs, id_rt, id_rd;
   logic [5:0]    id_funct;
   logic          ex_valid, ex_reg_dst, ex_reg_write, ex_ext_op, ex_alu_src;
   logic          ex_mem_write, ex_mem_to_reg, ex_beq, ex_bne, ex_j, stall;
   logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
   logic [4:0]    ex_rs, ex_rt, ex_wreg;
   logic [5:0]    ex_funct;
   logic [CW-1:0] stall_cnt, flush_cnt;

   id_ex_stage #(.DATA_W(DW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write), .id_ext_op(id_ext_op),
      .id_alu_src(id_alu_src), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
      .id_beq(id_beq), .id_bne(id_bne), .id_j(id_j),
      .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm16(id_imm16), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_funct(id_funct), .flush(flush),
      .ex_valid(ex_valid), .ex_reg_dst(ex_reg_dst), .ex_reg_write(ex_reg_write),
      .ex_ext_op(ex_ext_op), .ex_alu_src(ex_alu_src), .ex_mem_write(ex_mem_write),
      .ex_mem_to_reg(ex_mem_to_reg), .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_j(ex_j),
      .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg), .ex_funct(ex_funct),
      .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   typedef struct {
      logic        valid;
      logic [8:0]  ctrl;
      logic [31:0] pc4, rs_data, rt_data;
      logic [15:0] imm16;
      logic [4:0]  rs, rt, rd;
      logic [5:0]  funct;
      logic        flush;
   } inp_t;

   typedef struct {
      logic        valid;
      logic [8:0]  ctrl;
      logic        dp;
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, wreg;
      logic [5:0]  funct;
      logic [3:0]  scnt, fcnt;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;

   // reference model: what the EX slot holds, at instruction granularity
   logic       m_valid, m_load;
   logic [4:0] m_dest;
   int         m_scnt, m_fcnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [8:0] ex_ctrl_vec();
      return {ex_reg_dst, ex_reg_write, ex_ext_op, ex_alu_src, ex_mem_write,
              ex_mem_to_reg, ex_beq, ex_bne, ex_j};
   endfunction

   function automatic inp_t mk(input logic [8:0] c, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input logic [15:0] imm, input logic fl);
      inp_t s;
      s.valid = 1'b1; s.ctrl = c; s.rs = rs; s.rt = rt; s.rd = rd; s.imm16 = imm;
      s.flush = fl; s.pc4 = $urandom; s.rs_data = $urandom; s.rt_data = $urandom;
      s.funct = 6'($urandom);
      return s;
   endfunction

   function automatic inp_t rand_inp();
      inp_t s;
      s = mk(9'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 16'($urandom), $urandom_range(0, 7) == 0);
      s.valid = ($urandom_range(0, 3) != 0);
      return s;
   endfunction

   task automatic apply(input inp_t s);
      id_valid = s.valid;
      {id_reg_dst, id_reg_write, id_ext_op, id_alu_src, id_mem_write,
       id_mem_to_reg, id_beq, id_bne, id_j} = s.ctrl;
      id_pc4 = s.pc4; id_rs_data = s.rs_data; id_rt_data = s.rt_data;
      id_imm16 = s.imm16; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd;
      id_funct = s.funct; flush = s.flush;
   endtask

   // one cycle: starts and ends on a falling edge
   task automatic drive(input inp_t s);
      exp_t e;
      logic hz, reads_rt;
      apply(s);
      #1;
      reads_rt = s.ctrl[8] | s.ctrl[4] | s.ctrl[2] | s.ctrl[1];
      hz = m_valid && m_load && (m_dest != 0) && s.valid && !s.flush &&
           ((m_dest == s.rs) || (m_dest == s.rt && reads_rt));
      check("stall", stall, hz);
      e.pc4 = s.pc4; e.rs_data = s.rs_data; e.rt_data = s.rt_data;
      e.imm = s.ctrl[6] ? 32'($signed(s.imm16)) : 32'(s.imm16);
      e.rs = s.rs; e.rt = s.rt; e.wreg = s.ctrl[8] ? s.rd : s.rt; e.funct = s.funct;
      if (s.flush || hz) begin
         e.valid = 1'b0; e.ctrl = '0; e.dp = 1'b0;
      end else begin
         e.valid = s.valid; e.ctrl = s.valid ? s.ctrl : 9'h0; e.dp = 1'b1;
      end
      if (hz && m_scnt < 15) m_scnt++;
      if (s.flush && m_fcnt < 15) m_fcnt++;
      e.scnt = 4'(m_scnt); e.fcnt = 4'(m_fcnt);
      sb.push_back(e);
      m_valid = e.valid;
      m_load = e.valid && s.ctrl[3];
      if (e.dp) m_dest = e.wreg;
      @(negedge clk);
   endtask

   // reset asserted mid-cycle; everything must clear before the next edge
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("rst_valid", ex_valid, 0);
      check("rst_ctrl", ex_ctrl_vec(), 0);
      check("rst_pc4", ex_pc4, 0);
      check("rst_rs_data", ex_rs_data, 0);
      check("rst_rt_data", ex_rt_data, 0);
      check("rst_imm", ex_imm, 0);
      check("rst_regs", {ex_rs, ex_rt, ex_wreg, ex_funct}, 0);
      check("rst_cnts", {stall_cnt, flush_cnt}, 0);
      check("rst_stall", stall, 0);
      m_valid = 1'b0; m_load = 1'b0; m_dest = '0; m_scnt = 0; m_fcnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // monitor: compares every registered EX output against the scoreboard
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin : cmp
            exp_t e;
            e = sb.pop_front();
            check("ex_valid", ex_valid, e.valid);
            check("ex_ctrl", ex_ctrl_vec(), e.ctrl);
            check("stall_cnt", stall_cnt, e.scnt);
            check("flush_cnt", flush_cnt, e.fcnt);
            if (e.dp) begin
               check("ex_pc4", ex_pc4, e.pc4);
               check("ex_rs_data", ex_rs_data, e.rs_data);
               check("ex_rt_data", ex_rt_data, e.rt_data);
               check("ex_imm", ex_imm, e.imm);
               check("ex_rs_rt", {ex_rs, ex_rt}, {e.rs, e.rt});
               check("ex_wreg", ex_wreg, e.wreg);
               check("ex_funct", ex_funct, e.funct);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      inp_t add_i;
      rst_n = 1'b1;
      apply(mk(9'h0, 0, 0, 0, 0, 0));
      id_valid = 1'b0;
      @(negedge clk);
      do_reset();

      // immediate extension
      drive(mk(C_ADDI_S, 1, 2, 0, 16'h8000, 0));
      check("imm_sext", ex_imm, 32'hFFFF8000);
      drive(mk(C_ADDI_Z, 1, 2, 0, 16'h8000, 0));
      check("imm_zext", ex_imm, 32'h00008000);

      // load-use: one bubble then the add loads
      do_reset();
      drive(mk(C_LW, 1, 5, 0, 16'h0004, 0));
      add_i = mk(C_ADD, 5, 2, 7, 16'h0, 0);
      drive(add_i);
      check("lu_bubble", ex_valid, 0);
      drive(add_i);
      check("lu_loaded", {ex_valid, ex_wreg}, {1'b1, 5'd7});
      check("lu_stall_cnt", stall_cnt, 1);

      // hazard together with flush
      do_reset();
      drive(mk(C_LW, 1, 5, 0, 16'h0004, 0));
      drive(mk(C_ADD, 5, 2, 7, 16'h0, 1));
      check("fl_bubble", ex_valid, 0);
      check("fl_cnts", {stall_cnt, flush_cnt}, {4'd0, 4'd1});

      // load into $0 never stalls
      drive(mk(C_LW, 1, 0, 0, 16'h0004, 0));
      drive(mk(C_ADD, 0, 3, 4, 16'h0, 0));
      check("r0_loaded", ex_valid, 1);

      // stall counter saturation
      do_reset();
      repeat (20) begin
         drive(mk(C_LW, 1, 5, 0, 16'h0, 0));
         drive(mk(C_ADD, 5, 1, 6, 16'h0, 0));
      end
      check("stall_sat", stall_cnt, 4'hF);

      // reset while stalled, then normal load
      drive(mk(C_LW, 1, 5, 0, 16'h0, 0));
      add_i = mk(C_ADD, 3, 5, 6, 16'h0, 0);
      apply(add_i);
      #1;
      check("pre_rst_stall", stall, 1);
      do_reset();
      drive(add_i);
      check("post_rst_load", ex_valid, 1);

      // randomized traffic
      do_reset();
      repeat (300) drive(rand_inp());

      // reset mid-cycle with a valid instruction in EX
      drive(mk(C_ADD, 1, 2, 3, 16'h1234, 0));
      check("pre_rst_valid", ex_valid, 1);
      do_reset();

      check("sb_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
